// File: rtl/lut_neuron_stream.sv
// Streaming LUT neuron: LANES words per beat index one runtime-programmable truth table.
// Two-register pipeline; the table is cleared to DEFAULT_OUT after every reset before traffic is accepted.
module lut_neuron_stream #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 2,
    parameter int LANES     = 1,
    parameter logic [OUT_WIDTH-1:0] DEFAULT_OUT = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [IN_WIDTH-1:0]            cfg_addr,
    input  logic [OUT_WIDTH-1:0]           cfg_data,
    output logic                           cfg_ready,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [LANES*IN_WIDTH-1:0]      s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [LANES*OUT_WIDTH-1:0]     m_data
);
    localparam int DEPTH = 1 << IN_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                       state, state_nxt;
    logic [IN_WIDTH-1:0]          clr_cnt, clr_cnt_nxt;
    logic [OUT_WIDTH-1:0]         tbl [DEPTH];
    logic                         tbl_we;
    logic [IN_WIDTH-1:0]          tbl_addr;
    logic [OUT_WIDTH-1:0]         tbl_data;
    logic                         adv;
    logic                         v1;
    logic [LANES*IN_WIDTH-1:0]    s1_data;
    logic [LANES*OUT_WIDTH-1:0]   lookup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The clear sweep owns the table write port; config writes during INIT are simply lost.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        tbl_we      = 1'b0;
        tbl_addr    = cfg_addr;
        tbl_data    = cfg_data;
        cfg_ready   = 1'b0;
        case (state)
            INIT: begin
                tbl_we      = 1'b1;
                tbl_addr    = clr_cnt;
                tbl_data    = DEFAULT_OUT;
                clr_cnt_nxt = clr_cnt + IN_WIDTH'(1);
                if (clr_cnt == '1)
                    state_nxt = RUN;
            end
            RUN: begin
                cfg_ready = 1'b1;
                tbl_we    = cfg_we;
            end
            default: state_nxt = INIT;
        endcase
    end

    // No reset on the table itself: its contents are rebuilt by the INIT sweep.
    always_ff @(posedge clk) begin
        if (tbl_we)
            tbl[tbl_addr] <= tbl_data;
    end

    always_comb begin
        lookup = '0;
        for (int k = 0; k < LANES; k++)
            lookup[k*OUT_WIDTH +: OUT_WIDTH] = tbl[s1_data[k*IN_WIDTH +: IN_WIDTH]];
    end

    assign adv     = !m_valid || m_ready;
    assign s_ready = (state == RUN) && adv;

    // Both stages advance together; a same-cycle table write lands after the stage-2 capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_data <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (adv) begin
            v1      <= s_valid && s_ready;
            m_valid <= v1;
            if (s_valid && s_ready)
                s1_data <= s_data;
            if (v1)
                m_data <= lookup;
        end
    end
endmodule
